exu_trap_ctrl: RTL and testbench

//  Parametrised M-mode trap controller for the EXU. Next generation of the exception-only

---
 rtl/exu_trap_ctrl_pkg.sv | 22 ++
 rtl/exu_trap_ctrl_irq_sync_edge.sv | 68 ++++++
 rtl/exu_trap_ctrl.sv | 168 ++++++++++++++++
 tb/tb_exu_trap_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_trap_ctrl_pkg.sv
// exu_trap_ctrl_pkg
//   Shared definitions for the EXU M-mode trap controller:
//   - exception/interrupt cause codes (low bits of mcause)
//   - trap FSM state encoding
package exu_trap_ctrl_pkg;

  // Exception codes (mcause MSB = 0)
  localparam logic [3:0] CAUSE_ILG   = 4'd2;
  localparam logic [3:0] CAUSE_BRK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL = 4'd11;

  // Interrupt codes (mcause MSB = 1)
  localparam logic [3:0] CAUSE_MSI   = 4'd3;
  localparam logic [3:0] CAUSE_MTI   = 4'd7;
  localparam logic [3:0] CAUSE_MEI   = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } trap_state_e;

endpackage

// File: rtl/exu_trap_ctrl_irq_sync_edge.sv
// irq_sync_edge
//   One external interrupt line: optional synchroniser chain followed by a
//   pending latch that is either level-following or rising-edge latched.
// Ports:
//   clk    in  core clock
//   rst_n  in  async active-low reset
//   irq_in in  raw (possibly asynchronous) interrupt line
//   clr    in  clear the edge pending bit (line was taken); ignored in level mode
//   pend   out pending indication for this line
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_in,
  input  logic clr,
  output logic pend
);

  logic synced;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= irq_in;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign synced = sync_q[SYNC_STAGES-1];
    end else begin : g_bypass
      assign synced = irq_in;
    end
  endgenerate

  generate
    if (EDGE) begin : g_edge
      logic prev_q;
      logic pend_q;

      // A new rising edge in the same cycle as a clear keeps the line pending.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= 1'b0;
          pend_q <= 1'b0;
        end else begin
          prev_q <= synced;
          pend_q <= (synced & ~prev_q) | (pend_q & ~clr);
        end
      end

      assign pend = pend_q;
    end else begin : g_level
      logic clr_unused;
      assign clr_unused = clr;
      assign pend       = synced;
    end
  endgenerate

endmodule

// File: rtl/exu_trap_ctrl.sv
// exu_trap_ctrl
//   M-mode trap controller for the EXU. Arbitrates synchronous exceptions
//   (illegal, ebreak, ecall) and interrupts (external, software, timer) at
//   instruction boundaries, captures mcause/mepc/mtval/irq id and hands the
//   trap to the CSR/fetch path over a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   hs_in4ex_vld/rdy    instruction presented at EX boundary / EX may retire
//   i_pc, i_instr       PC and raw encoding of the presented instruction
//   i_ecabr             [1]=ecall, [0]=ebreak
//   i_ilg               illegal instruction
//   i_mstatus_mie       global M interrupt enable
//   i_meie/i_mtie/i_msie class interrupt enables
//   i_irq_ext           external interrupt lines (async)
//   i_irq_tmr/i_irq_sw  timer / software interrupt (level, synchronous)
//   o_trap_vld/i_trap_rdy trap request handshake
//   o_int_ena           trap taken strobe
//   o_mcause/o_mepc/o_mtval/o_irq_id captured trap information
module exu_trap_ctrl
  import exu_trap_ctrl_pkg::*;
#(
  parameter int unsigned          XLEN        = 32,
  parameter int unsigned          NUM_EXT     = 4,
  parameter logic [NUM_EXT-1:0]   EXT_EDGE    = '0,
  parameter int unsigned          SYNC_STAGES = 2,
  localparam int unsigned         IDW         = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hs_in4ex_vld,
  output logic               hs_in4ex_rdy,
  input  logic [XLEN-1:0]    i_pc,
  input  logic [31:0]        i_instr,
  input  logic [1:0]         i_ecabr,
  input  logic               i_ilg,
  input  logic               i_mstatus_mie,
  input  logic               i_meie,
  input  logic               i_mtie,
  input  logic               i_msie,
  input  logic [NUM_EXT-1:0] i_irq_ext,
  input  logic               i_irq_tmr,
  input  logic               i_irq_sw,
  output logic               o_trap_vld,
  input  logic               i_trap_rdy,
  output logic               o_int_ena,
  output logic [XLEN-1:0]    o_mcause,
  output logic [XLEN-1:0]    o_mepc,
  output logic [XLEN-1:0]    o_mtval,
  output logic [IDW-1:0]     o_irq_id
);

  trap_state_e        state_q;
  logic [NUM_EXT-1:0] ext_pend;
  logic [NUM_EXT-1:0] ext_clr;
  logic [NUM_EXT-1:0] ext_en;
  logic               is_ext_q;

  logic               trap_hit;
  logic               trap_acc;
  logic               is_ext_d;
  logic               is_int_d;
  logic               found;
  logic [3:0]         code_d;
  logic [IDW-1:0]     id_d;
  logic [XLEN-1:0]    cause_d;
  logic [XLEN-1:0]    tval_d;

  generate
    for (genvar g = 0; g < NUM_EXT; g++) begin : g_ext
      irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE        (EXT_EDGE[g])
      ) u_irq_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_in (i_irq_ext[g]),
        .clr    (ext_clr[g]),
        .pend   (ext_pend[g])
      );
    end
  endgenerate

  assign hs_in4ex_rdy = (state_q == ST_IDLE);
  assign o_trap_vld   = (state_q == ST_REQ);
  assign trap_acc     = o_trap_vld & i_trap_rdy;
  assign o_int_ena    = trap_acc;

  // Only the external line recorded with the accepted trap is cleared.
  always_comb begin
    ext_clr = '0;
    for (int unsigned i = 0; i < NUM_EXT; i++) begin
      ext_clr[i] = trap_acc & is_ext_q & (o_irq_id == IDW'(i));
    end
  end

  // Fixed-priority cause selection; exceptions always beat interrupts.
  always_comb begin
    ext_en   = ext_pend & {NUM_EXT{i_mstatus_mie & i_meie}};
    code_d   = '0;
    id_d     = '0;
    is_int_d = 1'b0;
    is_ext_d = 1'b0;
    trap_hit = 1'b1;
    found    = 1'b0;

    if (i_ilg) begin
      code_d = CAUSE_ILG;
    end else if (i_ecabr[0]) begin
      code_d = CAUSE_BRK;
    end else if (i_ecabr[1]) begin
      code_d = CAUSE_ECALL;
    end else if (|ext_en) begin
      code_d   = CAUSE_MEI;
      is_int_d = 1'b1;
      is_ext_d = 1'b1;
      for (int unsigned i = 0; i < NUM_EXT; i++) begin
        if (ext_en[i] && !found) begin
          found = 1'b1;
          id_d  = IDW'(i);
        end
      end
    end else if (i_mstatus_mie & i_msie & i_irq_sw) begin
      code_d   = CAUSE_MSI;
      is_int_d = 1'b1;
    end else if (i_mstatus_mie & i_mtie & i_irq_tmr) begin
      code_d   = CAUSE_MTI;
      is_int_d = 1'b1;
    end else begin
      trap_hit = 1'b0;
    end

    cause_d            = '0;
    cause_d[3:0]       = code_d;
    cause_d[XLEN-1]    = is_int_d;
    tval_d             = i_ilg ? XLEN'(i_instr) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      o_mcause <= '0;
      o_mepc   <= '0;
      o_mtval  <= '0;
      o_irq_id <= '0;
      is_ext_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hs_in4ex_vld && trap_hit) begin
            state_q  <= ST_REQ;
            o_mcause <= cause_d;
            o_mepc   <= i_pc;
            o_mtval  <= tval_d;
            o_irq_id <= id_d;
            is_ext_q <= is_ext_d;
          end
        end
        ST_REQ: begin
          if (i_trap_rdy) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_trap_ctrl.sv
module tb_exu_trap_ctrl;

  localparam int NE = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vld;
  logic          rdy;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic [1:0]    ecabr;
  logic          ilg;
  logic          mie, meie, mtie, msie;
  logic [NE-1:0] irq_ext;
  logic          irq_tmr, irq_sw;
  logic          trap_vld, trap_rdy, int_ena;
  logic [31:0]   mcause, mepc, mtval;
  logic [1:0]    irq_id;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exu_trap_ctrl #(
    .XLEN        (32),
    .NUM_EXT     (NE),
    .EXT_EDGE    (4'b0001),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hs_in4ex_vld  (vld),
    .hs_in4ex_rdy  (rdy),
    .i_pc          (pc),
    .i_instr       (instr),
    .i_ecabr       (ecabr),
    .i_ilg         (ilg),
    .i_mstatus_mie (mie),
    .i_meie        (meie),
    .i_mtie        (mtie),
    .i_msie        (msie),
    .i_irq_ext     (irq_ext),
    .i_irq_tmr     (irq_tmr),
    .i_irq_sw      (irq_sw),
    .o_trap_vld    (trap_vld),
    .i_trap_rdy    (trap_rdy),
    .o_int_ena     (int_ena),
    .o_mcause      (mcause),
    .o_mepc        (mepc),
    .o_mtval       (mtval),
    .o_irq_id      (irq_id)
  );

  // ---------------- reference model ----------------
  // Line 0 is edge-latched, lines 1..3 are level; synced line = input two samples ago.
  bit          m_req;
  logic [31:0] m_cause, m_epc, m_tval;
  logic [1:0]  m_id;
  bit          m_ext;
  bit          m_ep0, m_prev0;
  logic [3:0]  m_s1, m_s2;

  function automatic bit decide(input logic [3:0] pend, output logic [31:0] cause,
                                output logic [1:0] id, output bit ext);
    cause = 32'h0; id = 2'd0; ext = 1'b0; decide = 1'b1;
    if (ilg)                          cause = 32'd2;
    else if (ecabr[0])                cause = 32'd3;
    else if (ecabr[1])                cause = 32'd11;
    else if (mie && meie && pend != 0) begin
      cause = 32'h8000000B; ext = 1'b1;
      for (int k = NE - 1; k >= 0; k--) if (pend[k]) id = 2'(k);
    end
    else if (mie && msie && irq_sw)   cause = 32'h80000003;
    else if (mie && mtie && irq_tmr)  cause = 32'h80000007;
    else                              decide = 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0]  pend;
    logic [31:0] c;
    logic [1:0]  id;
    bit          ex, hit, taken;
    if (!rst_n) begin
      m_req = 0; m_cause = 0; m_epc = 0; m_tval = 0; m_id = 0; m_ext = 0;
      m_ep0 = 0; m_prev0 = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      pend  = {m_s2[3:1], m_ep0};
      taken = m_req && trap_rdy;
      hit   = decide(pend, c, id, ex);
      hit   = hit && !m_req && vld;
      m_ep0 = (m_s2[0] && !m_prev0) || (m_ep0 && !(taken && m_ext && m_id == 2'd0));
      m_prev0 = m_s2[0];
      m_s2 = m_s1;
      m_s1 = irq_ext;
      if (taken) m_req = 0;
      else if (hit) begin
        m_req = 1; m_cause = c; m_epc = pc; m_tval = ilg ? instr : 32'h0; m_id = id; m_ext = ex;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    vld = 0; pc = 0; instr = 0; ecabr = 0; ilg = 0; mie = 0; meie = 0; mtie = 0; msie = 0;
    irq_ext = 0; irq_tmr = 0; irq_sw = 0; trap_rdy = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) cyc();
    checks++; if (trap_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b want=0", trap_vld); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%0b want=1", rdy); end
    checks++; if (mcause !== 32'h0) begin failures++; $display("FAIL reset_mcause got=%h want=0", mcause); end
    checks++; if (mepc !== 32'h0) begin failures++; $display("FAIL reset_mepc got=%h want=0", mepc); end
    checks++; if (mtval !== 32'h0) begin failures++; $display("FAIL reset_mtval got=%h want=0", mtval); end
    checks++; if (irq_id !== 2'd0) begin failures++; $display("FAIL reset_irq_id got=%0d want=0", irq_id); end
    checks++; if (int_ena !== 1'b0) begin failures++; $display("FAIL reset_int_ena got=%0b want=0", int_ena); end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_ilg_hold();
    logic [31:0] ins;
    ins = $urandom;
    instr = ins; pc = 32'h100; ilg = 1; ecabr = 2'b10; vld = 1;
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL ilg_rdy_idle got=%0b want=1", rdy); end
    cyc();
    vld = 0; ilg = 0; ecabr = 0; instr = 0; pc = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (trap_vld !== 1'b1) begin failures++; $display("FAIL ilg_vld c%0d got=%0b want=1", i, trap_vld); end
      checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL ilg_rdy c%0d got=%0b want=0", i, rdy); end
      checks++; if (mcause !== 32'h2) begin failures++; $display("FAIL ilg_mcause c%0d got=%h want=2", i, mcause); end
      checks++; if (mepc !== 32'h100) begin failures++; $display("FAIL ilg_mepc c%0d got=%h want=100", i, mepc); end
      checks++; if (mtval !== ins) begin failures++; $display("FAIL ilg_mtval c%0d got=%h want=%h", i, mtval, ins); end
      checks++; if (int_ena !== 1'b0) begin failures++; $display("FAIL ilg_int_ena c%0d got=%0b want=0", i, int_ena); end
      if (i < 3) cyc();
    end
    trap_rdy = 1;
    #1;
    checks++; if (int_ena !== 1'b1) begin failures++; $display("FAIL ilg_take got=%0b want=1", int_ena); end
    cyc();
    trap_rdy = 0;
    checks++; if (trap_vld !== 1'b0) begin failures++; $display("FAIL ilg_release got=%0b want=0", trap_vld); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL ilg_rdy_back got=%0b want=1", rdy); end
  endtask

  task automatic test_ext_level();
    logic [31:0] p;
    p = $urandom;
    mie = 1; meie = 1; irq_ext = 4'b0110;
    repeat (3) cyc();
    checks++; if (trap_vld !== 1'b0) begin failures++; $display("FAIL lvl_no_vld got=%0b want=0", trap_vld); end
    pc = p; vld = 1;
    cyc();
    vld = 0;
    checks++; if (trap_vld !== 1'b1) begin failures++; $display("FAIL lvl_vld got=%0b want=1", trap_vld); end
    checks++; if (mcause !== 32'h8000000B) begin failures++; $display("FAIL lvl_mcause got=%h want=8000000b", mcause); end
    checks++; if (irq_id !== 2'd1) begin failures++; $display("FAIL lvl_irq_id got=%0d want=1", irq_id); end
    checks++; if (mepc !== p) begin failures++; $display("FAIL lvl_mepc got=%h want=%h", mepc, p); end
    checks++; if (mtval !== 32'h0) begin failures++; $display("FAIL lvl_mtval got=%h want=0", mtval); end
    trap_rdy = 1;
    cyc();
    trap_rdy = 0; irq_ext = 0;
    repeat (3) cyc();
  endtask

  task automatic take_edge_trap(input string tag);
    pc = $urandom; vld = 1;
    cyc();
    vld = 0;
    checks++; if (trap_vld !== 1'b1) begin failures++; $display("FAIL %s_vld got=%0b want=1", tag, trap_vld); end
    checks++; if (mcause !== 32'h8000000B) begin failures++; $display("FAIL %s_mcause got=%h want=8000000b", tag, mcause); end
    checks++; if (irq_id !== 2'd0) begin failures++; $display("FAIL %s_irq_id got=%0d want=0", tag, irq_id); end
  endtask

  task automatic test_ext_edge();
    mie = 1; meie = 1;
    irq_ext = 4'b0001;
    cyc();
    irq_ext = 0;
    repeat (5) cyc();
    take_edge_trap("edge1");
    trap_rdy = 1;
    cyc();
    trap_rdy = 0;
    vld = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (trap_vld !== 1'b0) begin failures++; $display("FAIL edge_cleared c%0d got=%0b want=0", i, trap_vld); end
    end
    vld = 0;
    irq_ext = 4'b0001;
    cyc();
    irq_ext = 0;
    repeat (5) cyc();
    take_edge_trap("edge2");
    // new pulse while the pending trap for line 0 is being taken
    trap_rdy = 1; irq_ext = 4'b0001;
    cyc();
    trap_rdy = 0; irq_ext = 0;
    repeat (4) cyc();
    take_edge_trap("edge3");
    trap_rdy = 1;
    cyc();
    trap_rdy = 0; mie = 0; meie = 0;
  endtask

  task automatic test_exc_vs_tmr();
    mie = 1; mtie = 1; irq_tmr = 1; ecabr = 2'b10; pc = 32'h2000; vld = 1;
    cyc();
    vld = 0; ecabr = 0;
    checks++; if (mcause !== 32'hB) begin failures++; $display("FAIL ecall_mcause got=%h want=b", mcause); end
    checks++; if (mepc !== 32'h2000) begin failures++; $display("FAIL ecall_mepc got=%h want=2000", mepc); end
    trap_rdy = 1;
    cyc();
    trap_rdy = 0; pc = 32'h2004; vld = 1;
    cyc();
    vld = 0;
    checks++; if (trap_vld !== 1'b1) begin failures++; $display("FAIL tmr_vld got=%0b want=1", trap_vld); end
    checks++; if (mcause !== 32'h80000007) begin failures++; $display("FAIL tmr_mcause got=%h want=80000007", mcause); end
    checks++; if (mepc !== 32'h2004) begin failures++; $display("FAIL tmr_mepc got=%h want=2004", mepc); end
    trap_rdy = 1;
    cyc();
    trap_rdy = 0; irq_tmr = 0; mtie = 0; mie = 0;
  endtask

  task automatic test_mie_off();
    mie = 0; meie = 1; mtie = 1; msie = 1; irq_ext = 4'b1111; irq_tmr = 1; irq_sw = 1; vld = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if (trap_vld !== 1'b0) begin failures++; $display("FAIL mie_off_vld c%0d got=%0b want=0", i, trap_vld); end
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL mie_off_rdy c%0d got=%0b want=1", i, rdy); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_req();
    ilg = 1; instr = 32'hDEAD_BEEF; pc = 32'h300; vld = 1;
    cyc();
    vld = 0; ilg = 0;
    checks++; if (trap_vld !== 1'b1) begin failures++; $display("FAIL rmid_pre_vld got=%0b want=1", trap_vld); end
    #2 rst_n = 0;
    #1;
    checks++; if (trap_vld !== 1'b0) begin failures++; $display("FAIL rmid_vld got=%0b want=0", trap_vld); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL rmid_rdy got=%0b want=1", rdy); end
    checks++; if (mcause !== 32'h0) begin failures++; $display("FAIL rmid_mcause got=%h want=0", mcause); end
    @(negedge clk);
    rst_n = 1;
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      vld      = $urandom_range(0, 1);
      ilg      = ($urandom_range(0, 7) == 0);
      ecabr    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      mie      = ($urandom_range(0, 3) != 0);
      meie     = $urandom_range(0, 1);
      mtie     = $urandom_range(0, 1);
      msie     = $urandom_range(0, 1);
      irq_tmr  = ($urandom_range(0, 5) == 0);
      irq_sw   = ($urandom_range(0, 5) == 0);
      trap_rdy = $urandom_range(0, 1);
      pc       = $urandom;
      instr    = $urandom;
      if ($urandom_range(0, 3) == 0) irq_ext = irq_ext ^ 4'($urandom_range(1, 15));
      #1;
      checks++; if (int_ena !== (m_req && trap_rdy)) begin failures++; $display("FAIL rnd_int_ena i%0d got=%0b want=%0b", i, int_ena, m_req && trap_rdy); end
      cyc();
      checks++; if (trap_vld !== m_req) begin failures++; $display("FAIL rnd_vld i%0d got=%0b want=%0b", i, trap_vld, m_req); end
      checks++; if (rdy !== !m_req) begin failures++; $display("FAIL rnd_rdy i%0d got=%0b want=%0b", i, rdy, !m_req); end
      checks++; if (mcause !== m_cause) begin failures++; $display("FAIL rnd_mcause i%0d got=%h want=%h", i, mcause, m_cause); end
      checks++; if (mepc !== m_epc) begin failures++; $display("FAIL rnd_mepc i%0d got=%h want=%h", i, mepc, m_epc); end
      checks++; if (mtval !== m_tval) begin failures++; $display("FAIL rnd_mtval i%0d got=%h want=%h", i, mtval, m_tval); end
      checks++; if (irq_id !== m_id) begin failures++; $display("FAIL rnd_irq_id i%0d got=%0d want=%0d", i, irq_id, m_id); end
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ilg_hold();
    test_ext_level();
    test_ext_edge();
    test_exc_vs_tmr();
    test_mie_off();
    test_reset_mid_req();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
